multi_4bits: RTL and testbench

- Sequential unsigned multiplier: iterative shift-and-add, one partial product per clock.
- Continuously watches operands A and B. When either changes, it recomputes and updates a registered product output.
- No handshake; the consumer treats Product_o as valid once bits+2 clock edges have passed after the last operand change.
- Leaf arithmetic block for small datapaths; the default configuration is 4x4 -> 8 bits.

---
 rtl/multi_pkg.sv | 30 +++
 rtl/multi_4bits_datapath.sv | 57 +++++
 rtl/multi_4bits.sv | 75 +++++++
 tb/tb_multi_4bits.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_pkg.sv
// ============================================================================
// Module : multi_pkg
// Brief  : Shared types and helpers for the iterative shift-and-add multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multi_pkg;

    localparam int MULT_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..value-1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_4bits_datapath.sv
// ============================================================================
// Module : multi_4bits_datapath
// Brief  : Accumulator, shifting operands and iteration counter for one
//          partial product per step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_4bits_datapath
    import multi_pkg::*;
#(
    parameter int bits = MULT_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [bits-1:0]   i_mcand,
    input  logic [bits-1:0]   i_mplier,
    output logic [2*bits-1:0] o_acc,
    output logic              o_last
);

    localparam int            CW     = clog2(bits);
    localparam logic [CW-1:0] C_LAST = CW'(bits - 1);

    logic [2*bits-1:0] r_acc;
    logic [2*bits-1:0] r_mcand;
    logic [bits-1:0]   r_mplier;
    logic [CW-1:0]     r_cnt;

    // Load has priority so an operand change restarts the iteration cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= {{bits{1'b0}}, i_mcand};
            r_mplier <= i_mplier;
            r_cnt    <= '0;
        end else if (i_step) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/multi_4bits.sv
// ============================================================================
// Module : multi_4bits
// Brief  : Sequential unsigned multiplier that recomputes A*B whenever the
//          operands change and publishes only completed products.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_4bits
    import multi_pkg::*;
#(
    parameter int bits = MULT_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [bits-1:0]   A,
    input  logic [bits-1:0]   B,
    output logic [2*bits-1:0] Product_o
);

    state_t            r_state;
    logic [bits-1:0]   r_opa;
    logic [bits-1:0]   r_opb;
    logic              w_change;
    logic              w_load;
    logic              w_step;
    logic [2*bits-1:0] w_acc;
    logic              w_last;

    always_comb begin
        w_change = ({A, B} != {r_opa, r_opb});
        w_load   = w_change;
        w_step   = (r_state == CALC) && !w_change;
    end

    multi_4bits_datapath #(
        .bits     (bits)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_mcand  (A),
        .i_mplier (B),
        .o_acc    (w_acc),
        .o_last   (w_last)
    );

    // An operand change in any state restarts; the product is written only in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_opa     <= '0;
            r_opb     <= '0;
            Product_o <= '0;
        end else if (w_change) begin
            r_opa   <= A;
            r_opb   <= B;
            r_state <= CALC;
        end else begin
            case (r_state)
                IDLE: r_state <= IDLE;
                CALC: if (w_last) r_state <= DONE;
                DONE: begin
                    Product_o <= w_acc;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_4bits.sv
// ============================================================================
// Module : tb_multi_4bits
// Brief  : Scoreboard bench for the 4-bit and 8-bit multiplier configurations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_4bits;
    import multi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  a4  = '0;
    logic [3:0]  b4  = '0;
    logic [7:0]  p4;
    logic [7:0]  a8  = '0;
    logic [7:0]  b8  = '0;
    logic [15:0] p8;

    multi_4bits #(.bits(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a4),
        .B         (b4),
        .Product_o (p4)
    );

    multi_4bits #(.bits(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .A         (a8),
        .B         (b8),
        .Product_o (p8)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          unit;
        logic [15:0] exp;
        string       name;
    } sb_t;

    sb_t  sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic abort_watch = 1'b0;
    logic hold_watch  = 1'b0;

    // Each entry pushed on a falling edge is checked just after the next rising edge.
    always @(posedge clk) begin : monitor
        sb_t         e;
        logic [15:0] act;
        #2;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = (e.unit == 8) ? p8 : {8'h00, p4};
            compared++;
            if (act !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %0d, expected %0d", e.name, act, e.exp);
            end
        end
        if (hold_watch) begin
            compared++;
            if (dut.r_state != IDLE) begin
                mismatched++;
                $display("FAIL hold_state: got state %0d, expected IDLE", dut.r_state);
            end
        end
    end

    // During the abort scenario the only legal output change is straight to 18.
    always @(p4) begin
        if (abort_watch) begin
            compared++;
            if (p4 !== 8'd18) begin
                mismatched++;
                $display("FAIL abort_glitch: got %0d, expected 18", p4);
            end
        end
        if (hold_watch) begin
            compared++;
            mismatched++;
            $display("FAIL hold_toggle: got %0d, expected steady 100", p4);
        end
    end

    task automatic expect_next(input int unit, input logic [15:0] v, input string nm);
        sb_q.push_back('{unit, v, nm});
    endtask

    // Called on the falling edge where operands were driven: old value after
    // rising edge k-1, new value after rising edge k.
    task automatic lat_check(input int unit, input logic [15:0] old_v,
                             input logic [15:0] new_v, input int k, input string nm);
        repeat (k - 2) @(negedge clk);
        expect_next(unit, old_v, {nm, "_early"});
        @(negedge clk);
        expect_next(unit, new_v, nm);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t dir_tbl[8] = '{
        '{4'd9,  4'd7,  8'd63},
        '{4'd15, 4'd15, 8'd225},
        '{4'd0,  4'd12, 8'd0},
        '{4'd12, 4'd0,  8'd0},
        '{4'd1,  4'd1,  8'd1},
        '{4'd15, 4'd1,  8'd15},
        '{4'd8,  4'd8,  8'd64},
        '{4'd6,  4'd11, 8'd66}
    };

    initial begin
        logic [7:0] prev;

        // Reset with non-zero operands waiting.
        #1 rst = 1'b0;
        a4 = 4'd3;
        b4 = 4'd5;
        repeat (2) @(negedge clk);
        expect_next(4, 16'd0, "reset_hold");
        @(negedge clk);
        rst = 1'b1;
        lat_check(4, 16'd0, 16'd15, 6, "post_reset");
        @(negedge clk);
        expect_next(4, 16'd15, "post_reset_stable");
        repeat (3) @(negedge clk);

        prev = 8'd15;
        foreach (dir_tbl[i]) begin
            @(negedge clk);
            a4 = dir_tbl[i].a;
            b4 = dir_tbl[i].b;
            lat_check(4, {8'h00, prev}, {8'h00, dir_tbl[i].p}, 6, "directed");
            prev = dir_tbl[i].p;
        end

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                a4 = 4'(i);
                b4 = 4'(j);
                repeat (9) @(negedge clk);
                expect_next(4, 16'(i * j), "sweep");
            end
        end

        // Abort: change B after two CALC edges; sweep left 225 on the output.
        @(negedge clk);
        a4 = 4'd6;
        b4 = 4'd7;
        abort_watch = 1'b1;
        repeat (3) @(negedge clk);
        b4 = 4'd3;
        lat_check(4, 16'd225, 16'd18, 6, "abort");
        @(negedge clk);
        abort_watch = 1'b0;

        // Hold: identical operands must not restart the engine.
        a4 = 4'd10;
        b4 = 4'd10;
        lat_check(4, 16'd18, 16'd100, 6, "hold_result");
        @(negedge clk);
        hold_watch = 1'b1;
        repeat (50) @(negedge clk);
        hold_watch = 1'b0;
        expect_next(4, 16'd100, "hold_end");
        @(negedge clk);

        // Asynchronous reset in the middle of a computation.
        a4 = 4'd13;
        b4 = 4'd11;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        compared++;
        if (p4 !== 8'd0) begin
            mismatched++;
            $display("FAIL async_reset: got %0d, expected 0", p4);
        end
        @(negedge clk);
        rst = 1'b1;
        lat_check(4, 16'd0, 16'd143, 6, "after_reset");

        // Wider configuration.
        @(negedge clk);
        a8 = 8'd255;
        b8 = 8'd255;
        lat_check(8, 16'd0, 16'd65025, 10, "bits8_max");

        repeat (3) @(negedge clk);
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
